dff_pipe: RTL and testbench

Parametrised elastic register pipeline: the multi-stage, multi-bit successor of the single-stage `dff`. It moves WIDTH-bit words through DEPTH register stages with a valid/ready handshake on both ends, a global stall enable, a synchronous flush, and an occupancy count. It sits between datapath blocks wherever the design needs registered latency that can absorb back-pressure without losing or duplicating words.

---
 rtl/dff_pkg.sv | 12 +
 rtl/dff_stage.sv | 53 +++++
 rtl/dff_pipe.sv | 102 ++++++++++
 tb/tb_dff_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Parameter limits live here so every user elaborates against the same bounds.
package dff_pkg;

  localparam int MAX_DEPTH = 16;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One elastic register stage: holds a word and its valid flag, advancing when
// the pipeline is allowed to move and this stage is ready.
module dff_stage #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             rdy_in,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             valid_d_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // rdy_in is this stage's own readiness from the chain; bubbles load as
  // invalid but never overwrite the data register.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load && rdy_in) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign data_o    = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Parametrised elastic register pipeline with valid/ready on both ends, a
// global stall enable, synchronous flush and a registered occupancy count.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int CW = count_width(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("dff_pipe: DEPTH %0d outside 1..%0d", DEPTH, MAX_DEPTH);
  end

  logic             advance;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  assign advance = enable && !flush;

  // Ready ripples from the output back to the input; an empty stage is
  // always ready so bubbles collapse.
  always_comb begin : ready_chain
    logic downstream;
    rdy        = '0;
    downstream = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i]     = !valid_q[i] || downstream;
      downstream = rdy[i];
    end
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             valid_in;
    logic [WIDTH-1:0] data_in;

    if (gi == 0) begin : g_head
      assign valid_in = in_valid;
      assign data_in  = in_data;
    end else begin : g_body
      assign valid_in = valid_q[gi-1];
      assign data_in  = data_q[gi-1];
    end

    dff_stage #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .load     (advance),
      .rdy_in   (rdy[gi]),
      .valid_i  (valid_in),
      .data_i   (data_in),
      .valid_o  (valid_q[gi]),
      .valid_d_o(valid_d[gi]),
      .data_o   (data_q[gi])
    );
  end

  // Popcount of the next valid vector keeps count aligned with valid.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign in_ready  = advance && rdy[0];
  assign out_valid = advance && valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a DEPTH=3 and a DEPTH=1 instance share one stimulus and
// are compared every cycle against a token-movement model of the pipeline.
module tb_dff_pipe;

  localparam logic [15:0] RV = 16'hA5A5;
  localparam int DEP [2] = '{3, 1};

  logic        clk = 1'b0;
  logic        reset, enable, flush, in_valid, out_ready;
  logic [15:0] in_data;

  logic        in_ready3, out_valid3;
  logic [15:0] out_data3;
  logic [1:0]  count3;
  logic        in_ready1, out_valid1;
  logic [15:0] out_data1;
  logic [0:0]  count1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit track   = 1'b0;
  int acc_cyc [2];
  int app_cyc [2];
  int peak    [2];

  bit          mv [2][16];
  logic [15:0] md [2][16];

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(16), .DEPTH(3), .RESET_VALUE(RV)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .count(count3)
  );

  dff_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VALUE(RV)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int occ(input int k);
    int n;
    n = 0;
    for (int p = 0; p < DEP[k]; p++) n += int'(mv[k][p]);
    return n;
  endfunction

  // A word can enter when any slot is free or the head word is leaving.
  function automatic bit e_in_ready(input int k);
    return enable && !flush && (occ(k) < DEP[k] || out_ready);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 16; p++) begin
        mv[k][p] = 1'b0;
        md[k][p] = RV;
      end
  endtask

  // Each word advances one slot whenever any slot ahead of it is free or the
  // head is being taken; the head word leaves when out_ready is high.
  task automatic model_advance();
    bit          nv [16];
    logic [15:0] nd [16];
    bit          fwd;
    bit          ir;
    int          d;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      d = DEP[k];
      if (flush) begin
        for (int p = 0; p < 16; p++) mv[k][p] = 1'b0;
      end else if (enable) begin
        ir = e_in_ready(k);
        for (int p = 0; p < 16; p++) begin
          nv[p] = 1'b0;
          nd[p] = md[k][p];
        end
        for (int p = 0; p < d; p++) begin
          if (mv[k][p]) begin
            fwd = out_ready;
            for (int q = p + 1; q < d; q++) if (!mv[k][q]) fwd = 1'b1;
            if (!fwd) nv[p] = 1'b1;
            else if (p < d - 1) begin
              nv[p+1] = 1'b1;
              nd[p+1] = md[k][p];
            end
          end
        end
        if (in_valid && ir) begin
          nv[0] = 1'b1;
          nd[0] = in_data;
        end
        for (int p = 0; p < 16; p++) begin
          mv[k][p] = nv[p];
          md[k][p] = nd[p];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d.in_ready", DEP[k]),
            32'(k == 0 ? in_ready3 : in_ready1), 32'(e_in_ready(k)));
      check($sformatf("d%0d.out_valid", DEP[k]),
            32'(k == 0 ? out_valid3 : out_valid1),
            32'(enable && !flush && mv[k][DEP[k]-1]));
      check($sformatf("d%0d.out_data", DEP[k]),
            32'(k == 0 ? out_data3 : out_data1), 32'(md[k][DEP[k]-1]));
      check($sformatf("d%0d.count", DEP[k]),
            (k == 0) ? 32'(count3) : 32'(count1), 32'(occ(k)));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    if (track) begin
      for (int k = 0; k < 2; k++) begin
        if (acc_cyc[k] < 0 && in_valid && e_in_ready(k) && in_data == 16'h8000)
          acc_cyc[k] = cyc;
        if (app_cyc[k] < 0 && (k == 0 ? out_valid3 : out_valid1) &&
            (k == 0 ? out_data3 : out_data1) == 16'h8000)
          app_cyc[k] = cyc;
      end
      if (int'(count3) > peak[0]) peak[0] = int'(count3);
      if (int'(count1) > peak[1]) peak[1] = int'(count1);
    end
    model_advance();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst.out_data", 32'(out_data3), 32'(RV));
    check("rst.count", 32'(count3), 32'd0);
    check("rst.out_valid", 32'(out_valid3), 32'd0);

    // Streaming
    for (int k = 0; k < 2; k++) begin acc_cyc[k] = -1; app_cyc[k] = -1; peak[k] = 0; end
    track = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 16'h8000; cycle();
    in_data = 16'h0001; cycle();
    in_data = 16'h1234; cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    track = 1'b0;
    check("stream.latency_d3", 32'(app_cyc[0] - acc_cyc[0]), 32'd3);
    check("stream.latency_d1", 32'(app_cyc[1] - acc_cyc[1]), 32'd1);
    check("stream.peak_d3", 32'(peak[0]), 32'd3);

    // Back-pressure
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(16'hB000 + i);
      cycle();
    end
    in_data = 16'hB003;
    #1;
    check("bp.in_ready_full", 32'(in_ready3), 32'd0);
    check("bp.count_full", 32'(count3), 32'd3);
    cycle();
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_drain", 32'(in_ready3), 32'd1);
    check("bp.head", 32'(out_data3), 32'hB000);
    cycle();
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("bp.count_kept", 32'(count3), 32'd3);
    check("bp.next_head", 32'(out_data3), 32'hB001);

    // Enable stall with pipeline partly filled
    out_ready = 1'b1;
    repeat (4) cycle();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'hC000; cycle();
    in_data = 16'hC001; cycle();
    enable = 1'b0; out_ready = 1'b1; in_data = 16'hC002;
    repeat (5) begin
      #1;
      check("en.in_ready", 32'(in_ready3), 32'd0);
      check("en.out_valid", 32'(out_valid3), 32'd0);
      check("en.count", 32'(count3), 32'd2);
      cycle();
    end
    enable = 1'b1; in_valid = 1'b0;
    repeat (5) cycle();

    // Flush with two words in flight
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'hD000; cycle();
    in_data = 16'hD001; cycle();
    flush = 1'b1; out_ready = 1'b1; in_data = 16'hD002;
    #1;
    check("flush.in_ready", 32'(in_ready3), 32'd0);
    check("flush.out_valid", 32'(out_valid3), 32'd0);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush.count", 32'(count3), 32'd0);
    check("flush.out_valid_after", 32'(out_valid3), 32'd0);
    repeat (4) cycle();

    // Asynchronous reset between edges while full
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(16'hE000 + i);
      cycle();
    end
    #1;
    reset = 1'b1;
    #1;
    check("areset.out_valid", 32'(out_valid3), 32'd0);
    check("areset.count", 32'(count3), 32'd0);
    check("areset.out_data", 32'(out_data3), 32'(RV));
    check("areset.out_data_d1", 32'(out_data1), 32'(RV));
    model_reset();
    reset = 1'b0; in_valid = 1'b0;
    cycle();

    // Randomised traffic
    repeat (400) begin
      enable    = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 16'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
